// File: rtl/sysid_pkg.sv
// Shared constants for the system-ID register bank: word map, CAPS layout, CTRL bits.
package sysid_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [ADDR_W-1:0] ADDR_ID      = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_TSTAMP  = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_CAPS    = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_UPT_LO  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_UPT_HI  = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_CTRL    = 3'd6;

  localparam int unsigned CAPS_VER_LSB  = 16;
  localparam int unsigned CAPS_UPTW_LSB = 8;
  localparam int unsigned CAPS_UPT_BIT  = 0;

  localparam int unsigned CTRL_CLR_BIT = 0;
  localparam int unsigned READ_LATENCY = 1;

  // Byte-lane merge of a write into an existing 32-bit word.
  function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old_val,
                                                 input logic [DATA_W-1:0] wdata,
                                                 input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < int'(BE_W); b++) begin
      if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sysid_uptime_ctr.sv
// Free-running uptime counter with synchronous clear and a high-half snapshot
// captured when the low half is read, so LO/HI pairs stay coherent.
module sysid_uptime_ctr #(
  parameter int unsigned UPTIME_W = 48
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        snap,
  output logic [31:0] lo,
  output logic [31:0] hi_shadow
);

  logic [UPTIME_W-1:0]  cnt;
  logic [UPTIME_W-33:0] hi_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      hi_q <= '0;
    end else begin
      cnt <= clr ? '0 : cnt + UPTIME_W'(1);
      if (snap) hi_q <= cnt[UPTIME_W-1:32];
    end
  end

  assign lo        = cnt[31:0];
  assign hi_shadow = 32'(hi_q);

endmodule

// File: rtl/sysid_regbank.sv
// Avalon-MM system-ID slave: ID, timestamp, CAPS, scratch and optional uptime counter.
// Uptime words 4..6 are built only when SYSID_UPTIME_EN is defined.
module sysid_regbank
  import sysid_pkg::*;
#(
  parameter logic [31:0] ID_VALUE     = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter logic [15:0] VERSION      = 16'h0001,
  parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000,
  parameter int unsigned UPTIME_W     = 48
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

`ifdef SYSID_UPTIME_EN
  localparam bit UPT_EN = 1'b1;
`else
  localparam bit UPT_EN = 1'b0;
`endif

  localparam logic [31:0] CAPS_VAL =
      (32'(VERSION) << CAPS_VER_LSB)
    | (UPT_EN ? (32'(8'(UPTIME_W)) << CAPS_UPTW_LSB) : 32'h0)
    | (32'(UPT_EN) << CAPS_UPT_BIT);

  logic        wr_en_c;
  logic [31:0] scratch;
  logic [31:0] upt_lo_c;
  logic [31:0] upt_hi_c;
  logic [31:0] rdata_c;

  // A read in the same cycle wins; the write is dropped.
  assign wr_en_c = write & ~read;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= SCRATCH_INIT;
    end else if (wr_en_c && address == ADDR_SCRATCH) begin
      scratch <= be_merge(scratch, writedata, byteenable);
    end
  end

`ifdef SYSID_UPTIME_EN
  logic clr_c;
  logic snap_c;

  assign clr_c  = wr_en_c && (address == ADDR_CTRL) && writedata[CTRL_CLR_BIT];
  assign snap_c = read && (address == ADDR_UPT_LO);

  sysid_uptime_ctr #(
    .UPTIME_W (UPTIME_W)
  ) u_upt (
    .clock     (clock),
    .reset_n   (reset_n),
    .clr       (clr_c),
    .snap      (snap_c),
    .lo        (upt_lo_c),
    .hi_shadow (upt_hi_c)
  );
`else
  assign upt_lo_c = 32'h0;
  assign upt_hi_c = 32'h0;
`endif

  always_comb begin
    rdata_c = 32'h0;
    case (address)
      ADDR_ID:      rdata_c = ID_VALUE;
      ADDR_TSTAMP:  rdata_c = TIMESTAMP;
      ADDR_CAPS:    rdata_c = CAPS_VAL;
      ADDR_SCRATCH: rdata_c = scratch;
      ADDR_UPT_LO:  rdata_c = upt_lo_c;
      ADDR_UPT_HI:  rdata_c = upt_hi_c;
      default:      rdata_c = 32'h0;
    endcase
  end

  // Fixed one-cycle read latency; readdata holds between reads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= 32'h0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rdata_c;
    end
  end

endmodule
